// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants, instruction field widths and scanner state type
package led_pkg;

   localparam int MODE_W = 8;

   // Matrix controller instruction modes
   localparam logic [MODE_W-1:0] MODE_IDLE   = 8'h00;
   localparam logic [MODE_W-1:0] MODE_CLEAR  = 8'h01;
   localparam logic [MODE_W-1:0] MODE_FILL   = 8'h02;
   localparam logic [MODE_W-1:0] MODE_RS_PIC = 8'h03;
   localparam logic [MODE_W-1:0] MODE_RS_ANI = 8'h04;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DWELL,
      ST_SWAP
   } state_t;

endpackage

// File: rtl/led_frame_scanner_if.sv
// rtl/led_frame_scanner_if.sv - host write/swap port and matrix instruction port
interface led_frame_scanner_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8
);
   import led_pkg::*;

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int IW = MODE_W + ROWS + COLS;

   logic          enable;
   logic          wr_en;
   logic [RW-1:0] wr_row;
   logic [COLS-1:0] wr_data;
   logic          swap_req;
   logic          swap_ack;
   logic          frame_done;
   logic          busy;
   logic          start;
   logic [IW-1:0] w_instruction;

   modport master (
      output enable, wr_en, wr_row, wr_data, swap_req,
      input  swap_ack, frame_done, busy, start, w_instruction
   );

   modport slave (
      input  enable, wr_en, wr_row, wr_data, swap_req,
      output swap_ack, frame_done, busy, start, w_instruction
   );

endinterface

// File: rtl/led_frame_bank.sv
// rtl/led_frame_bank.sv - double-buffered frame store; writes hit the back bank, reads see the front
module led_frame_bank #(
   parameter int p_row_num    = 8,
   parameter int p_column_num = 8,
   parameter int RW           = (p_row_num > 1) ? $clog2(p_row_num) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [RW-1:0]           wr_row,
   input  logic [p_column_num-1:0] wr_data,
   input  logic                    toggle,
   input  logic [RW-1:0]           rd_row,
   output logic [p_column_num-1:0] rd_data
);

   logic [p_row_num-1:0][p_column_num-1:0] bank0;
   logic [p_row_num-1:0][p_column_num-1:0] bank1;
   logic                                   front_sel;
   logic                                   wr_ok;

   assign wr_ok = wr_en && (int'(wr_row) < p_row_num);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank0     <= '0;
         bank1     <= '0;
         front_sel <= 1'b0;
      end else begin
         if (wr_ok) begin
            if (front_sel)
               bank0[wr_row] <= wr_data;
            else
               bank1[wr_row] <= wr_data;
         end
         if (toggle)
            front_sel <= ~front_sel;
      end
   end

   // During a toggle cycle, return what the front will hold next cycle,
   // including a write landing in the outgoing back bank this cycle.
   always_comb begin
      rd_data = front_sel ? bank1[rd_row] : bank0[rd_row];
      if (toggle) begin
         rd_data = front_sel ? bank0[rd_row] : bank1[rd_row];
         if (wr_ok && (wr_row == rd_row))
            rd_data = wr_data;
      end
   end

endmodule

// File: rtl/led_frame_scanner.sv
// rtl/led_frame_scanner.sv - row-scans the front frame into matrix instructions with tear-free swaps
module led_frame_scanner
   import led_pkg::*;
#(
   parameter int p_frequency    = 50_000_000,
   parameter int p_row_num      = 8,
   parameter int p_column_num   = 8,
   parameter int p_row_dwell_us = 1000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   led_frame_scanner_if.slave   bus
);

   localparam int ROW_DWELL_CYCLES = (p_frequency / 1_000_000) * p_row_dwell_us;
   localparam int RW = (p_row_num > 1) ? $clog2(p_row_num) : 1;
   localparam int CW = $clog2(ROW_DWELL_CYCLES);
   localparam int IW = MODE_W + p_row_num + p_column_num;
   localparam logic [RW-1:0] LAST_ROW   = RW'(p_row_num - 1);
   localparam logic [CW-1:0] DWELL_LOAD = CW'(ROW_DWELL_CYCLES - 2);

   generate
      if (ROW_DWELL_CYCLES < 4) begin : g_dwell_check
         $error("ROW_DWELL_CYCLES must be at least 4");
      end
   endgenerate

   state_t                  state;
   logic [RW-1:0]           row;
   logic [RW-1:0]           rd_row;
   logic [CW-1:0]           cnt;
   logic                    pending;
   logic                    toggle;
   logic [p_column_num-1:0] nxt_data;
   logic [p_row_num-1:0]    row_oh;
   logic [IW-1:0]           issue_word;

   logic          start_q;
   logic          ack_q;
   logic          done_q;
   logic          busy_q;
   logic [IW-1:0] instr_q;

   assign toggle = (state == ST_SWAP);

   // Row that the next ISSUE will present; only meaningful on a transition into ST_ISSUE.
   always_comb begin
      rd_row = '0;
      if (state == ST_DWELL && row != LAST_ROW)
         rd_row = row + RW'(1);
      row_oh         = '0;
      row_oh[rd_row] = 1'b1;
      issue_word     = {MODE_RS_PIC, row_oh, nxt_data};
   end

   led_frame_bank #(
      .p_row_num    (p_row_num),
      .p_column_num (p_column_num),
      .RW           (RW)
   ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bus.wr_en),
      .wr_row  (bus.wr_row),
      .wr_data (bus.wr_data),
      .toggle  (toggle),
      .rd_row  (rd_row),
      .rd_data (nxt_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         row     <= '0;
         cnt     <= '0;
         pending <= 1'b0;
         start_q <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         instr_q <= '0;
      end else begin
         start_q <= 1'b0;
         ack_q   <= 1'b0;
         done_q  <= 1'b0;
         if (bus.swap_req)
            pending <= 1'b1;

         case (state)
            ST_IDLE: begin
               if (bus.enable) begin
                  busy_q <= 1'b1;
                  row    <= '0;
                  if (pending) begin
                     state <= ST_SWAP;
                     ack_q <= 1'b1;
                  end else begin
                     state   <= ST_ISSUE;
                     start_q <= 1'b1;
                     instr_q <= issue_word;
                  end
               end
            end

            ST_ISSUE: begin
               cnt   <= DWELL_LOAD;
               state <= ST_DWELL;
            end

            ST_DWELL: begin
               if (cnt != '0) begin
                  cnt <= cnt - CW'(1);
               end else if (row != LAST_ROW) begin
                  if (bus.enable) begin
                     row     <= row + RW'(1);
                     state   <= ST_ISSUE;
                     start_q <= 1'b1;
                     instr_q <= issue_word;
                  end else begin
                     row     <= '0;
                     state   <= ST_IDLE;
                     busy_q  <= 1'b0;
                     instr_q <= '0;
                  end
               end else begin
                  done_q <= 1'b1;
                  row    <= '0;
                  if (!bus.enable) begin
                     state   <= ST_IDLE;
                     busy_q  <= 1'b0;
                     instr_q <= '0;
                  end else if (pending) begin
                     state <= ST_SWAP;
                     ack_q <= 1'b1;
                  end else begin
                     state   <= ST_ISSUE;
                     start_q <= 1'b1;
                     instr_q <= issue_word;
                  end
               end
            end

            ST_SWAP: begin
               // Clearing here also absorbs a request arriving in this same cycle.
               pending <= 1'b0;
               row     <= '0;
               state   <= ST_ISSUE;
               start_q <= 1'b1;
               instr_q <= issue_word;
            end

            default: begin
               state   <= ST_IDLE;
               busy_q  <= 1'b0;
               instr_q <= '0;
            end
         endcase
      end
   end

   assign bus.start         = start_q;
   assign bus.swap_ack      = ack_q;
   assign bus.frame_done    = done_q;
   assign bus.busy          = busy_q;
   assign bus.w_instruction = instr_q;

endmodule

// File: tb/tb_led_frame_scanner.sv
// tb/tb_led_frame_scanner.sv - directed bench for led_frame_scanner
module tb_led_frame_scanner;
   import led_pkg::*;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int IW   = 8 + ROWS + COLS;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   led_frame_scanner_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

   led_frame_scanner #(
      .p_frequency    (1_000_000),
      .p_row_num      (ROWS),
      .p_column_num   (COLS),
      .p_row_dwell_us (10)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         row;
      logic [7:0] bmp;
      int         gap;
      int         fd;
   } vec_t;

   vec_t vt [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] ins(input int r, input logic [7:0] b);
      logic [7:0] oh;
      oh = 8'(1 << r);
      return {MODE_RS_PIC, oh, b};
   endfunction

   // Advance until the next start pulse, tallying swap_ack/frame_done pulses on the way.
   task automatic next_start(input int budget, input bit req_on_ack, output int gap,
                             output logic [IW-1:0] instr, output int acks, output int fd);
      gap = 0; acks = 0; fd = 0;
      do begin
         @(negedge clk);
         gap++;
         bus.swap_req = 1'b0;
         if (bus.swap_ack) begin
            acks++;
            if (req_on_ack) bus.swap_req = 1'b1;
         end
         if (bus.frame_done) fd++;
      end while (!bus.start && gap < budget);
      instr = bus.w_instruction;
      if (!bus.start) begin
         tests++;
         fails++;
         $display("FAIL start_timeout: got no start within %0d cycles", budget);
         gap = -1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap, acks, fd, bad, n;
      logic [IW-1:0] instr;

      for (int r = 1; r < 8; r++) vt[r-1] = '{r, 8'(1 << r), 10, 0};
      vt[7] = '{0, 8'h01, 10, 1};

      bus.enable = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.swap_req = 1'b0;

      // Reset and quiet idle
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_start", bus.start, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_instr", bus.w_instruction, 0);
      chk("rst_ack", bus.swap_ack, 0);
      chk("rst_done", bus.frame_done, 0);
      rst_n = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (bus.start || bus.busy || bus.swap_ack || bus.frame_done || bus.w_instruction != '0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // Load back frame, swap, and start scanning
      for (int r = 0; r < 8; r++) begin
         bus.wr_en = 1'b1; bus.wr_row = 3'(r); bus.wr_data = 8'(1 << r);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      bus.swap_req = 1'b1;
      @(negedge clk);
      bus.swap_req = 1'b0;
      bus.enable = 1'b1;
      @(negedge clk);
      chk("first_swap_ack", bus.swap_ack, 1);
      chk("first_swap_nostart", bus.start, 0);
      chk("first_swap_busy", bus.busy, 1);
      @(negedge clk);
      chk("first_start", bus.start, 1);
      chk("first_instr", bus.w_instruction, ins(0, 8'h01));
      chk("first_ack_gone", bus.swap_ack, 0);

      for (int i = 0; i < 8; i++) begin
         next_start(30, 1'b0, gap, instr, acks, fd);
         chk($sformatf("scan%0d_gap", i), gap, vt[i].gap);
         chk($sformatf("scan%0d_instr", i), instr, ins(vt[i].row, vt[i].bmp));
         chk($sformatf("scan%0d_done", i), fd, vt[i].fd);
         chk($sformatf("scan%0d_noack", i), acks, 0);
      end

      // Back-buffer rewrite mid-frame, row 3 = FF
      for (int r = 0; r < 8; r++) begin
         bus.wr_en = 1'b1; bus.wr_row = 3'(r); bus.wr_data = (r == 3) ? 8'hFF : 8'(1 << r);
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      for (int r = 1; r <= 8; r++) begin
         next_start(30, 1'b0, gap, instr, acks, fd);
         chk($sformatf("noswap_row%0d", r % 8), instr, ins(r % 8, 8'(1 << (r % 8))));
      end

      // Two requests within one frame; still the old frame until the boundary
      for (int r = 1; r < 8; r++) begin
         if (r == 1 || r == 5) bus.swap_req = 1'b1;
         next_start(30, 1'b0, gap, instr, acks, fd);
         chk($sformatf("pend_row%0d", r), instr, ins(r, 8'(1 << r)));
      end
      next_start(30, 1'b1, gap, instr, acks, fd);
      chk("swap_gap", gap, 11);
      chk("swap_acks", acks, 1);
      chk("swap_done", fd, 1);
      chk("swap_row0", instr, ins(0, 8'h01));

      n = 0;
      for (int r = 1; r < 8; r++) begin
         next_start(30, 1'b0, gap, instr, acks, fd);
         n += acks;
         chk($sformatf("new_row%0d", r), instr, ins(r, (r == 3) ? 8'hFF : 8'(1 << r)));
      end
      chk("new_frame_noack", n, 0);
      next_start(30, 1'b0, gap, instr, acks, fd);
      chk("single_swap_gap", gap, 10);
      chk("single_swap_acks", acks, 0);
      chk("single_swap_row0", instr, ins(0, 8'h01));

      // Drop enable during row 4
      for (int r = 1; r <= 4; r++) next_start(30, 1'b0, gap, instr, acks, fd);
      chk("row4_instr", instr, ins(4, 8'h10));
      repeat (3) @(negedge clk);
      bus.enable = 1'b0;
      n = 3; bad = 0;
      while (bus.busy && n < 30) begin
         @(negedge clk);
         n++;
         if (bus.busy && (bus.start || bus.w_instruction != ins(4, 8'h10))) bad++;
      end
      chk("drop_dwell_len", n, 10);
      chk("drop_hold", bad, 0);
      chk("drop_instr_clr", bus.w_instruction, 0);
      chk("drop_nostart", bus.start, 0);
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.start || bus.busy) bad++;
      end
      chk("drop_idle", bad, 0);
      bus.enable = 1'b1;
      @(negedge clk);
      chk("reen_start", bus.start, 1);
      chk("reen_instr", bus.w_instruction, ins(0, 8'h01));

      // Asynchronous reset mid-dwell
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("async_busy", bus.busy, 0);
      chk("async_instr", bus.w_instruction, 0);
      chk("async_start", bus.start, 0);
      bus.enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.start || bus.busy || bus.w_instruction != '0) bad++;
      end
      chk("post_rst_idle", bad, 0);
      bus.enable = 1'b1;
      @(negedge clk);
      chk("post_rst_start", bus.start, 1);
      chk("post_rst_cleared", bus.w_instruction, ins(0, 8'h00));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/led_frame_scanner.md
Name: led_frame_scanner

Overview:
- Upstream feeder for the LED matrix controller.
- Holds a double-buffered 8x8 monochrome frame.
- Continuously row-scans the front buffer by issuing one row-scan-picture instruction (start pulse plus instruction word) per row at a fixed dwell rate.
- Host logic writes the back buffer and requests a tear-free swap, which is applied only at a frame boundary.

Parameters:
- p_frequency, 50_000_000: system clock frequency in Hz.
- p_row_num, 8: matrix rows.
- p_column_num, 8: matrix columns.
- p_row_dwell_us, 1000: time each row is held, in µs.
- ROW_DWELL_CYCLES, (p_frequency/1_000_000)*p_row_dwell_us: derived cycles per row. Elaboration error if < 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enable  in  1  scanning enabled while high.
- wr_en  in  1  back-buffer row write strobe.
- wr_row  in  $clog2(p_row_num)  row index to write.
- wr_data  in  p_column_num  column bitmap; bit i = column i lit.
- swap_req  in  1  one-cycle request to promote back buffer to front.
- swap_ack  out  1  one-cycle pulse when the swap is applied.
- frame_done  out  1  one-cycle pulse after the last row's dwell ends.
- busy  out  1  high in any state other than ST_IDLE.
- start  out  1  one-cycle instruction strobe to the matrix controller.
- w_instruction  out  8+p_row_num+p_column_num  {mode[7:0], row one-hot, column bitmap}.

Behaviour:
- Reset (async, rst_n=0):
  - start, swap_ack, frame_done, busy = 0.
  - w_instruction = 0.
  - Both banks cleared; front select = bank 0; swap pending = 0; row index = 0; dwell counter = 0; state = ST_IDLE.
  - Reset asserted mid-scan takes effect immediately with no completion of the current row.
- All outputs are registered.
- States:
  - ST_IDLE
    - start=0, w_instruction=0.
    - Transition when enable=1 sampled: to ST_SWAP if a swap is pending, else to ST_ISSUE with row=0.
  - ST_ISSUE (1 cycle)
    - start=1.
    - w_instruction = {MODE_RS_PIC, 1<<row, front[row]}.
    - Dwell counter loaded with ROW_DWELL_CYCLES-2. Next state: ST_DWELL.
  - ST_DWELL
    - start=0; w_instruction held unchanged. Counter decrements each cycle.
    - At counter 0, if row != p_row_num-1:
      - enable=1 → row+1, go to ST_ISSUE.
      - enable=0 → ST_IDLE, row=0.
    - At counter 0, if row == p_row_num-1:
      - Pulse frame_done; row=0.
      - enable=0 → ST_IDLE.
      - Else if swap pending → ST_SWAP.
      - Else → ST_ISSUE.
  - ST_SWAP (1 cycle)
    - Toggle front select, clear pending, pulse swap_ack. Next state: ST_ISSUE, row 0.
- Row spacing:
  - Consecutive start pulses are exactly ROW_DWELL_CYCLES apart during steady scan.
  - At a swap frame boundary the spacing is ROW_DWELL_CYCLES+1.
  - Because ROW_DWELL_CYCLES ≥ 4, the downstream IDLE→RS→DONE→IDLE sequence (3 cycles) always completes before the next start.
- Latency: enable sampled high in cycle N with no swap pending → start=1 in cycle N+1. With a swap pending → start in N+2.
- Writes:
  - Always target the bank that is back in that cycle; never visible on outputs until swapped.
  - wr_row ≥ p_row_num: write ignored.
- swap_req:
  - Sets pending (sticky). A repeat request while pending is absorbed, giving a single swap.
  - swap_req and ST_SWAP in the same cycle: the current swap applies and pending is cleared.
- Write in the same cycle as ST_SWAP: lands in the pre-toggle back bank, so it becomes visible in the new front.
- After a swap, the back bank holds the old front frame. The host must rewrite any rows it changes.
- Empty rows (bitmap 0) are still issued, which keeps scan timing uniform.
- enable deassertion mid-row: the current row completes its full dwell, then the block returns to ST_IDLE. It never truncates a dwell.

Decomposition:
- Package led_pkg:
  - Mode code constants mirroring LED_defines.vh (MODE_IDLE … MODE_RS_ANI, with MODE_RS_PIC used here).
  - Instruction field widths.
  - typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DWELL, ST_SWAP}.
- Sub-module led_frame_bank:
  - Two p_row_num × p_column_num register banks with front select.
  - Write port targets the back bank; combinational read port reads the front bank.
  - toggle input, async active-low clear.

Test Plan (p_frequency=1_000_000, p_row_dwell_us=10 → ROW_DWELL_CYCLES=10):
1. Reset then idle, enable=0 for 50 cycles → start, busy, w_instruction all 0; no pulses.
2. Write rows 0..7 = 8'h01<<r, swap_req, enable=1 → swap_ack one cycle after enable is sampled, start the following cycle with w_instruction={MODE_RS_PIC,8'h01,8'h01}. Next starts at +10 cycles carry rows 8'h02.. with matching bitmaps. frame_done pulses after row 7's dwell ends, and the wrap to row 0 follows.
3. Without a swap, write back row 3 = 8'hFF mid-frame → issued row-3 bitmap remains the old front value for all frames until swap_req. After the swap it is 8'hFF beginning at the next row-0 issue, never mid-frame.
4. Drop enable during row 4's dwell → row 4 holds for its full 10 cycles; the block enters ST_IDLE, and busy falls with outputs cleared. Re-enable → restarts at row 0.
5. Pulse swap_req twice within a frame, plus one in the ST_SWAP cycle → exactly one swap_ack per frame boundary, and the front select toggles once.
6. Assert rst_n=0 in the middle of a ST_DWELL → all outputs and banks clear in the same cycle, with no start emitted. After release, the block remains idle until enable is sampled.
